// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main control FSM for the multicycle MIPS datapath. Each instruction is
//   walked through FETCH / DECODE / EXEC / MEM / WB. Memory accesses stall on
//   i_mem_ready, unknown opcodes are trapped and skipped, and every
//   instruction that completes (all but trapped ones) bumps a retire counter.
//
//   Build option: define MC_CTRL_JAL_EN to build the JAL (op 03) and
//   JR (op 00 / funct 08) states. Without it those encodings trap, and
//   reg_dst / mem_to_reg never take the value 2'b10.
//
// Parameters
//   ALUOP_W  width of o_alu_op (3-bit codes zero-extended when wider)
//   CNT_W    width of o_instr_cnt (wraps to 0)
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_op         IR[31:26], valid from DECODE onward
//   i_funct      IR[5:0], only used to spot JR
//   i_mem_ready  memory done; looked at in FETCH, MEM_RD and MEM_WR only
//   o_pc_write   unconditional PC load
//   o_pc_wr_beq  PC load if ALU zero
//   o_pc_wr_bne  PC load if ALU not zero
//   o_iord       memory address: 0 PC, 1 ALUOut
//   o_mem_read   memory read strobe
//   o_mem_write  memory write strobe
//   o_ir_write   instruction register load
//   o_reg_dst    00 rt, 01 rd, 10 $ra
//   o_mem_to_reg 00 ALUOut, 01 MDR, 10 PC
//   o_reg_write  register-file write
//   o_alu_src_a  0 PC, 1 rs
//   o_alu_src_b  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   o_pc_source  00 ALU, 01 ALUOut, 10 jump target, 11 rs
//   o_alu_op     ADD 011, SUB 001, R 111, ADDI 100, ORI 101, ANDI 110, LUI 010
//   o_illegal_op one-cycle pulse while in TRAP
//   o_instr_cnt  retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [5:0]         i_op,
  input  logic [5:0]         i_funct,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_pc_wr_beq,
  output logic               o_pc_wr_bne,
  output logic               o_iord,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic [1:0]         o_reg_dst,
  output logic [1:0]         o_mem_to_reg,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_pc_source,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_illegal_op,
  output logic [CNT_W-1:0]   o_instr_cnt
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC     = 4'd3;
  localparam logic [3:0] S_R_WB     = 4'd4;
  localparam logic [3:0] S_IMM_EXEC = 4'd5;
  localparam logic [3:0] S_IMM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_MEM_WB   = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
`ifdef MC_CTRL_JAL_EN
  localparam logic [3:0] S_JR       = 4'd13;
  localparam logic [3:0] S_JAL      = 4'd14;
`endif
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [2:0] AOP_ADD  = 3'b011;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_R    = 3'b111;
  localparam logic [2:0] AOP_ADDI = 3'b100;
  localparam logic [2:0] AOP_ORI  = 3'b101;
  localparam logic [2:0] AOP_ANDI = 3'b110;
  localparam logic [2:0] AOP_LUI  = 3'b010;

  logic [3:0]       r_state;
  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_retire;
  logic [2:0]       w_alu_op;
  logic [2:0]       w_imm_aop;
  logic             w_is_jr;

  assign w_is_jr = (i_funct == 6'h08);

  // Immediate ALU op follows the opcode still held in IR.
  always_comb begin
    case (i_op)
      6'h0d:   w_imm_aop = AOP_ORI;
      6'h0c:   w_imm_aop = AOP_ANDI;
      6'h0f:   w_imm_aop = AOP_LUI;
      default: w_imm_aop = AOP_ADDI;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_FETCH;
      S_FETCH:  if (i_mem_ready) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (i_op)
`ifdef MC_CTRL_JAL_EN
          6'h00:                      w_state_nxt = w_is_jr ? S_JR : S_EXEC;
          6'h03:                      w_state_nxt = S_JAL;
`else
          6'h00:                      w_state_nxt = w_is_jr ? S_TRAP : S_EXEC;
`endif
          6'h08, 6'h0d, 6'h0c, 6'h0f: w_state_nxt = S_IMM_EXEC;
          6'h23, 6'h2b:               w_state_nxt = S_MEM_ADDR;
          6'h04, 6'h05:               w_state_nxt = S_BRANCH;
          6'h02:                      w_state_nxt = S_JUMP;
          default:                    w_state_nxt = S_TRAP;
        endcase
      end
      S_EXEC:     w_state_nxt = S_R_WB;
      S_IMM_EXEC: w_state_nxt = S_IMM_WB;
      S_MEM_ADDR: w_state_nxt = (i_op == 6'h2b) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (i_mem_ready) w_state_nxt = S_MEM_WB;
      S_MEM_WR:   if (i_mem_ready) w_state_nxt = S_FETCH;
      S_R_WB, S_IMM_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_TRAP:
                  w_state_nxt = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JR, S_JAL: w_state_nxt = S_FETCH;
`endif
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // An instruction retires on the edge leaving its last state; TRAP never does.
  always_comb begin
    case (r_state)
      S_R_WB, S_IMM_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
`ifdef MC_CTRL_JAL_EN
      S_JR, S_JAL:                                  w_retire = 1'b1;
`endif
      S_MEM_WR:                                     w_retire = i_mem_ready;
      default:                                      w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  // Output decode. FETCH gates its PC/IR loads with i_mem_ready so a stalled
  // fetch does not advance the PC.
  always_comb begin
    o_pc_write   = 1'b0;
    o_pc_wr_beq  = 1'b0;
    o_pc_wr_bne  = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_dst    = 2'b00;
    o_mem_to_reg = 2'b00;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_pc_source  = 2'b00;
    o_illegal_op = 1'b0;
    w_alu_op     = 3'b000;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
        o_alu_src_b = 2'b01;
        w_alu_op    = AOP_ADD;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        w_alu_op    = AOP_ADD;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        w_alu_op    = AOP_R;
      end
      S_R_WB: begin
        o_reg_dst   = 2'b01;
        o_reg_write = 1'b1;
      end
      S_IMM_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_alu_op    = w_imm_aop;
      end
      S_IMM_WB: o_reg_write = 1'b1;
      S_MEM_ADDR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        w_alu_op    = AOP_ADD;
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_mem_to_reg = 2'b01;
        o_reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        w_alu_op    = AOP_SUB;
        o_pc_source = 2'b01;
        o_pc_wr_beq = (i_op == 6'h04);
        o_pc_wr_bne = (i_op == 6'h05);
      end
      S_JUMP: begin
        o_pc_source = 2'b10;
        o_pc_write  = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JR: begin
        o_pc_source = 2'b11;
        o_pc_write  = 1'b1;
      end
      // PC still holds PC+4 here, so writing PC into $ra gives the link.
      S_JAL: begin
        o_pc_source  = 2'b10;
        o_pc_write   = 1'b1;
        o_reg_dst    = 2'b10;
        o_mem_to_reg = 2'b10;
        o_reg_write  = 1'b1;
      end
`endif
      S_TRAP: o_illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign o_alu_op    = ALUOP_W'(w_alu_op);
  assign o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw, beq, bne, iord, mr, mw, irw;
    logic [1:0] rdst, m2r;
    logic       rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] aop;
    logic       ill;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    string nm;
    vec_t  v;
  } exp_t;

  localparam int T_IDLE = 0, T_F = 1, T_D = 2, T_EX = 3, T_RWB = 4, T_IEX = 5,
                 T_IWB = 6, T_MA = 7, T_MRD = 8, T_MWB = 9, T_MWR = 10,
                 T_BR = 11, T_J = 12, T_JR = 13, T_JAL = 14, T_TRAP = 15;
`ifdef MC_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [5:0] i_op = '0, i_funct = '0;
  logic       i_mem_ready = 1'b0;
  logic       o_pc_write, o_pc_wr_beq, o_pc_wr_bne, o_iord, o_mem_read, o_mem_write;
  logic       o_ir_write, o_reg_write, o_alu_src_a, o_illegal_op;
  logic [1:0] o_reg_dst, o_mem_to_reg, o_alu_src_b, o_pc_source;
  logic [2:0] o_alu_op;
  logic [3:0] o_instr_cnt;

  multicycle_control_fsm #(.ALUOP_W(3), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op(i_op), .i_funct(i_funct),
    .i_mem_ready(i_mem_ready), .o_pc_write(o_pc_write), .o_pc_wr_beq(o_pc_wr_beq),
    .o_pc_wr_bne(o_pc_wr_bne), .o_iord(o_iord), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_ir_write(o_ir_write), .o_reg_dst(o_reg_dst),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_pc_source(o_pc_source), .o_alu_op(o_alu_op),
    .o_illegal_op(o_illegal_op), .o_instr_cnt(o_instr_cnt)
  );

  always #5 i_clk = ~i_clk;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] e_cnt = '0;

  // Hand-written expected control word for each state.
  function automatic vec_t st(input int s, input logic rdy, input logic [2:0] aop, input logic is_beq);
    vec_t v = '0;
    case (s)
      T_F:    begin v.mr = 1; v.irw = rdy; v.pcw = rdy; v.sb = 2'b01; v.aop = 3'b011; end
      T_D:    begin v.sb = 2'b11; v.aop = 3'b011; end
      T_EX:   begin v.sa = 1; v.aop = 3'b111; end
      T_RWB:  begin v.rdst = 2'b01; v.rw = 1; end
      T_IEX:  begin v.sa = 1; v.sb = 2'b10; v.aop = aop; end
      T_IWB:  begin v.rw = 1; end
      T_MA:   begin v.sa = 1; v.sb = 2'b10; v.aop = 3'b011; end
      T_MRD:  begin v.mr = 1; v.iord = 1; end
      T_MWB:  begin v.m2r = 2'b01; v.rw = 1; end
      T_MWR:  begin v.mw = 1; v.iord = 1; end
      T_BR:   begin v.sa = 1; v.aop = 3'b001; v.ps = 2'b01; v.beq = is_beq; v.bne = ~is_beq; end
      T_J:    begin v.ps = 2'b10; v.pcw = 1; end
      T_JR:   begin v.ps = 2'b11; v.pcw = 1; end
      T_JAL:  begin v.ps = 2'b10; v.pcw = 1; v.rdst = 2'b10; v.m2r = 2'b10; v.rw = 1; end
      T_TRAP: begin v.ill = 1; end
      default: ;
    endcase
    return v;
  endfunction

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input vec_t e);
    exp_t x;
    e.cnt = e_cnt;
    x.nm = nm;
    x.v = e;
    q.push_back(x);
    @(posedge i_clk);
    #1;
  endtask

  task automatic retire(input string nm, input int s, input logic [2:0] aop, input logic b);
    cyc(nm, st(s, 1'b1, aop, b));
    e_cnt = e_cnt + 4'd1;
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b0;
    e_cnt = '0;
    repeat (n) cyc("RESET", st(T_IDLE, 0, 0, 0));
    i_reset = 1'b1;
    cyc("IDLE", st(T_IDLE, 0, 0, 0));
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    repeat (fw) begin i_mem_ready = 0; cyc("FETCH_WAIT", st(T_F, 0, 0, 0)); end
    i_mem_ready = 1;
    cyc("FETCH", st(T_F, 1, 0, 0));
    i_op = o;
    i_funct = f;
    cyc("DECODE", st(T_D, 1, 0, 0));
    case (o)
      6'h00: begin
        if (f == 6'h08 && JAL_EN) retire("JR", T_JR, 0, 0);
        else if (f == 6'h08) cyc("TRAP_JR", st(T_TRAP, 1, 0, 0));
        else begin cyc("EXEC", st(T_EX, 1, 0, 0)); retire("R_WB", T_RWB, 0, 0); end
      end
      6'h08: begin cyc("ADDI", st(T_IEX, 1, 3'b100, 0)); retire("IMM_WB", T_IWB, 0, 0); end
      6'h0d: begin cyc("ORI",  st(T_IEX, 1, 3'b101, 0)); retire("IMM_WB", T_IWB, 0, 0); end
      6'h0c: begin cyc("ANDI", st(T_IEX, 1, 3'b110, 0)); retire("IMM_WB", T_IWB, 0, 0); end
      6'h0f: begin cyc("LUI",  st(T_IEX, 1, 3'b010, 0)); retire("IMM_WB", T_IWB, 0, 0); end
      6'h23: begin
        cyc("MEM_ADDR", st(T_MA, 1, 0, 0));
        repeat (mw) begin i_mem_ready = 0; cyc("MEM_RD_WAIT", st(T_MRD, 0, 0, 0)); end
        i_mem_ready = 1;
        cyc("MEM_RD", st(T_MRD, 1, 0, 0));
        retire("MEM_WB", T_MWB, 0, 0);
      end
      6'h2b: begin
        cyc("MEM_ADDR", st(T_MA, 1, 0, 0));
        repeat (mw) begin i_mem_ready = 0; cyc("MEM_WR_WAIT", st(T_MWR, 0, 0, 0)); end
        i_mem_ready = 1;
        retire("MEM_WR", T_MWR, 0, 0);
      end
      6'h04: retire("BEQ", T_BR, 0, 1);
      6'h05: retire("BNE", T_BR, 0, 0);
      6'h02: retire("JUMP", T_J, 0, 0);
      6'h03: begin
        if (JAL_EN) retire("JAL", T_JAL, 0, 0);
        else cyc("TRAP_JAL", st(T_TRAP, 1, 0, 0));
      end
      default: cyc("TRAP", st(T_TRAP, 1, 0, 0));
    endcase
  endtask

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    vec_t a;
    exp_t x;
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        a = '{o_pc_write, o_pc_wr_beq, o_pc_wr_bne, o_iord, o_mem_read, o_mem_write,
              o_ir_write, o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a,
              o_alu_src_b, o_pc_source, o_alu_op, o_illegal_op, o_instr_cnt};
        n_vec++;
        if (a !== x.v) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (cnt got %0d expected %0d)",
                   x.nm, a, x.v, a.cnt, x.v.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    @(posedge i_clk);
    #1;
    do_reset(3);                       // reset 3 cycles, IDLE, then FETCH
    instr(6'h00, 6'h20, 0, 0);         // R-type, count 0->1
    instr(6'h23, 6'h00, 0, 2);         // lw with 2 wait cycles in MEM_RD
    instr(6'h05, 6'h00, 0, 0);         // bne
    instr(6'h04, 6'h00, 1, 0);         // beq after a stalled fetch
    instr(6'h3f, 6'h00, 0, 0);         // illegal: not counted
    instr(6'h03, 6'h00, 0, 0);         // jal (or trap when not built)
    instr(6'h00, 6'h08, 0, 0);         // jr (or trap when not built)
    instr(6'h08, 6'h00, 0, 0);         // addi
    instr(6'h0d, 6'h00, 0, 0);         // ori
    instr(6'h0c, 6'h00, 0, 0);         // andi
    instr(6'h0f, 6'h00, 0, 0);         // lui
    instr(6'h2b, 6'h00, 0, 1);         // sw with 1 wait cycle
    instr(6'h02, 6'h00, 0, 0);         // j
    instr(6'h23, 6'h00, 0, 0);         // lw, no wait
    // Reset in the middle of an R-type: aborted, counter cleared.
    i_mem_ready = 1;
    cyc("FETCH", st(T_F, 1, 0, 0));
    i_op = 6'h00; i_funct = 6'h20;
    cyc("DECODE", st(T_D, 1, 0, 0));
    do_reset(2);
    // 16 jumps on a 4-bit counter: 15 then wrap to 0.
    repeat (16) instr(6'h02, 6'h00, 0, 0);
    i_mem_ready = 1;
    cyc("FETCH_AFTER_WRAP", st(T_F, 1, 0, 0));
    @(negedge i_clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
